retardador: RTL and testbench



---
 rtl/retardador.sv | 104 ++++++++++
 tb/tb_retardador.sv | 127 ++++++++++++
 2 files changed

// File: rtl/retardador.sv
// Delayed clock divider: holds out_clk low for START_DELAY cycles after reset, then
// toggles every HALF_PERIOD cycles. Define RETARDADOR_PULSE_EN for a one-cycle pulse per period.
module retardador #(
   parameter int HALF_PERIOD = 2,
   parameter int START_DELAY = 0
) (
   input  logic clk,
   input  logic reset,
   output logic out_clk
);

   // state   | meaning
   // ST_WAIT | start delay running, out_clk held low
   // ST_RUN  | half-period counter running, out_clk toggling

   localparam int MAXV = (HALF_PERIOD > START_DELAY) ? HALF_PERIOD : START_DELAY;
   localparam int CW   = $clog2(MAXV + 1);

   localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] DELAY_LAST = (START_DELAY > 0) ? CW'(START_DELAY - 1) : '0;

   generate
      if (HALF_PERIOD < 1) begin : g_bad_half
         $error("retardador: HALF_PERIOD must be >= 1");
      end
      if (START_DELAY < 0) begin : g_bad_delay
         $error("retardador: START_DELAY must be >= 0");
      end
   endgenerate

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // With no start delay there is nothing to wait for, so reset lands directly in RUN.
   localparam state_t ST_RESET = (START_DELAY == 0) ? ST_RUN : ST_WAIT;

   state_t        state, state_nxt;
   logic [CW-1:0] delay_cnt, delay_nxt;
   logic [CW-1:0] half_cnt, half_nxt;
   logic          wave, wave_nxt;
   logic          out_nxt;
   logic          half_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_RESET;
         delay_cnt <= '0;
         half_cnt  <= '0;
         wave      <= 1'b0;
         out_clk   <= 1'b0;
      end else begin
         state     <= state_nxt;
         delay_cnt <= delay_nxt;
         half_cnt  <= half_nxt;
         wave      <= wave_nxt;
         out_clk   <= out_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      delay_nxt = delay_cnt;
      half_nxt  = half_cnt;
      wave_nxt  = wave;
      half_done = (half_cnt == HALF_LAST);

      case (state)
         ST_WAIT: begin
            if (delay_cnt == DELAY_LAST) begin
               state_nxt = ST_RUN;
               delay_nxt = '0;
               half_nxt  = '0;
            end else begin
               delay_nxt = delay_cnt + CW'(1);
            end
         end
         ST_RUN: begin
            // Wrap and toggle share an edge so the period is exactly 2*HALF_PERIOD.
            if (half_done) begin
               half_nxt = '0;
               wave_nxt = ~wave;
            end else begin
               half_nxt = half_cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = ST_RESET;
            delay_nxt = '0;
            half_nxt  = '0;
            wave_nxt  = 1'b0;
         end
      endcase

`ifdef RETARDADOR_PULSE_EN
      // High for the one cycle after each edge where the square wave would rise.
      out_nxt = (state == ST_RUN) && half_done && !wave;
`else
      out_nxt = wave_nxt;
`endif
   end

endmodule

// File: tb/tb_retardador.sv
// Randomized self-checking bench for retardador: several parameter sets share one clock and
// reset, and each output is compared every cycle against an edge-count arithmetic model.
module tb_retardador;

   logic clk;
   logic reset;
   logic out_a, out_b, out_c, out_d;

   int n_checks = 0;
   int n_errors = 0;
   int n_edge   = 0;

   retardador #(.HALF_PERIOD(2), .START_DELAY(0)) dut_a (.clk(clk), .reset(reset), .out_clk(out_a));
   retardador #(.HALF_PERIOD(2), .START_DELAY(3)) dut_b (.clk(clk), .reset(reset), .out_clk(out_b));
   retardador #(.HALF_PERIOD(1), .START_DELAY(0)) dut_c (.clk(clk), .reset(reset), .out_clk(out_c));
   retardador #(.HALF_PERIOD(3), .START_DELAY(2)) dut_d (.clk(clk), .reset(reset), .out_clk(out_d));

   // Rising edges at 0, 20, 40, ... ns
   initial begin
      clk = 1'b1;
      forever #10 clk = ~clk;
   end

   // Edge number since the latest reset release; edges seen during reset do not count.
   always @(posedge clk or posedge reset) begin
      if (reset) n_edge <= 0;
      else       n_edge <= n_edge + 1;
   end

   // Expected output after edge n for a given (half period, start delay).
   function automatic logic model(input int n, input int h, input int s);
      int toggles;
      if (n < s + h) return 1'b0;
      toggles = (n - s) / h;
`ifdef RETARDADOR_PULSE_EN
      return ((n - s) % h == 0) && (toggles % 2 == 1);
`else
      return toggles % 2 == 1;
`endif
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t ns (edge %0d): got %b expected %b", tag, $time, n_edge, obs, exp);
      end
   endtask

   task automatic check_all();
      check("a_h2_s0", out_a, model(n_edge, 2, 0));
      check("b_h2_s3", out_b, model(n_edge, 2, 3));
      check("c_h1_s0", out_c, model(n_edge, 1, 0));
      check("d_h3_s2", out_d, model(n_edge, 3, 2));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a"}, out_a, 1'b0);
      check({tag, "_b"}, out_b, 1'b0);
      check({tag, "_c"}, out_c, 1'b0);
      check({tag, "_d"}, out_d, 1'b0);
   endtask

   task automatic run_cycles(input int k);
      repeat (k) begin
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      int wait_cycles;
      int hold_cycles;

      // Reset coincident with the t=0 edge; that edge must be ignored.
      reset = 1'b1;
      #5;
      check_zero("por");
      #5;
      reset = 1'b0;

      // Defaults: low through 30 ns, high at 50 ns, low at 90 ns, high at 130 ns.
      #20;
      check("plan_30ns", out_a, 1'b0);
      #20;
`ifdef RETARDADOR_PULSE_EN
      check("plan_50ns", out_a, 1'b1);
      #20;
      check("plan_70ns", out_a, 1'b0);
      #20;
`else
      check("plan_50ns", out_a, 1'b1);
      #20;
      check("plan_70ns", out_a, 1'b1);
      #20;
`endif
      check("plan_90ns", out_a, 1'b0);
      run_cycles(36);

      // Random asynchronous resets at random points of the run.
      for (int i = 0; i < 25; i++) begin
         wait_cycles = $urandom_range(0, 30);
         hold_cycles = $urandom_range(0, 2);
         run_cycles(wait_cycles);
         @(posedge clk);
         #($urandom_range(2, 7));
         reset = 1'b1;
         #1;
         check_zero("async_rst");
         repeat (hold_cycles) begin
            @(negedge clk);
            check_zero("hold_rst");
         end
         @(negedge clk);
         #($urandom_range(1, 8));
         reset = 1'b0;
         run_cycles($urandom_range(1, 4));
      end

      // Long final run to cover several full periods after the last restart.
      run_cycles(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
